// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter for the register-file write port.
// Ports: req0 (ALU) and req1 (load) valid/ready/addr/data in, registered wr_* out, pri debug.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_sel,
  output logic              pri
);

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic grant0;
  logic grant1;
  logic go;

  // A lone requester always wins; a tie goes to the priority holder.
  assign grant0 = req0_valid
                & (~req1_valid | (state == PRI0));
  assign grant1 = req1_valid
                & (~req0_valid | (state == PRI1));

  assign go = rst_n & ~hold;

  assign req0_ready = go & grant0;
  assign req1_ready = go & grant1;

  assign pri = (state == PRI1);

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      req0_ready: state_nxt = PRI1;
      req1_ready: state_nxt = PRI0;
      default:    state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= PRI0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_sel  <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_en <= 1'b0;
      if (req0_ready) begin
        wr_addr <= req0_addr;
        wr_data <= req0_data;
        wr_sel  <= 1'b0;
        // Register 0 is hard-wired: consume the request, skip the write.
        wr_en   <= (req0_addr != '0);
      end else if (req1_ready) begin
        wr_addr <= req1_addr;
        wr_data <= req1_data;
        wr_sel  <= 1'b1;
        wr_en   <= (req1_addr != '0);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed bench with a write scoreboard for wb_port_arbiter.
// Drives on negedge, checks ready before posedge and wr_* just after it.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_sel;
  logic        pri;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hold(hold),
    .req0_valid(req0_valid),
    .req0_addr(req0_addr),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr(req1_addr),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_sel(wr_sel),
    .pri(pri)
  );

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        sel;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          acc0 = 0;
  int          acc1 = 0;
  logic        m_pri = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_sel = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic rs,
                      input logic h,
                      input logic v0,
                      input logic [4:0] a0,
                      input logic [31:0] d0,
                      input logic v1,
                      input logic [4:0] a1,
                      input logic [31:0] d1);
    logic e0;
    logic e1;
    logic exp_en;
    exp_t e;
    @(negedge clk);
    rst_n = rs;
    hold = h;
    req0_valid = v0;
    req0_addr = a0;
    req0_data = d0;
    req1_valid = v1;
    req1_addr = a1;
    req1_data = d1;
    #1;
    e0 = rs && !h && v0 && (!v1 || !m_pri);
    e1 = rs && !h && v1 && (!v0 || m_pri);
    chk("ready0", 32'(req0_ready), 32'(e0));
    chk("ready1", 32'(req1_ready), 32'(e1));
    if (!rs) begin
      sb.delete();
      m_pri = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_sel = 1'b0;
    end else if (e0) begin
      sb.push_back('{a0 != 5'd0, a0, d0, 1'b0});
      m_pri = 1'b1;
      acc0++;
    end else if (e1) begin
      sb.push_back('{a1 != 5'd0, a1, d1, 1'b1});
      m_pri = 1'b0;
      acc1++;
    end
    @(posedge clk);
    #1;
    exp_en = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      exp_en = e.en;
      m_addr = e.addr;
      m_data = e.data;
      m_sel = e.sel;
    end
    chk("wr_en", 32'(wr_en), 32'(exp_en));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", wr_data, m_data);
    chk("wr_sel", 32'(wr_sel), 32'(m_sel));
    chk("pri", 32'(pri), 32'(m_pri));
  endtask

  initial begin
    rst_n = 1'b0;
    hold = 1'b0;
    req0_valid = 1'b0;
    req0_addr = '0;
    req0_data = '0;
    req1_valid = 1'b0;
    req1_addr = '0;
    req1_data = '0;

    // reset with both requesting, then release: port 0 wins
    step(0, 0, 1, 5'd5, 32'hAAAA0005, 1, 5'd7, 32'hBBBB0007);
    step(0, 0, 1, 5'd5, 32'hAAAA0005, 1, 5'd7, 32'hBBBB0007);
    step(1, 0, 1, 5'd5, 32'hAAAA0005, 1, 5'd7, 32'hBBBB0007);

    // continuous contention: strict alternation
    acc0 = 0;
    acc1 = 0;
    for (int i = 0; i < 6; i++)
      step(1, 0, 1, 5'd3, 32'hC0DE0003, 1, 5'd7, 32'hBBBB0007);
    chk("acc0", 32'(acc0), 32'd3);
    chk("acc1", 32'(acc1), 32'd3);

    // idle: no write, priority held
    step(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // single requester on port 1
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h00001234);
    chk("pri_single", 32'(pri), 32'd0);

    // write to register 0: consumed, no write
    step(1, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0);
    chk("pri_zero", 32'(pri), 32'd1);
    step(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // hold mid-stream, then resume with held priority
    step(1, 0, 1, 5'd4, 32'h44444444, 1, 5'd4, 32'h55555555);
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 5'd4, 32'h44444444, 1, 5'd4, 32'h55555555);
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 5'd4, 32'h44444444, 1, 5'd4, 32'h55555555);
    chk("pri_hold", 32'(pri), 32'd1);

    // reset mid-stream (pri=1), reset also beats hold
    step(0, 1, 1, 5'd6, 32'h66666666, 1, 5'd8, 32'h88888888);
    chk("pri_rst", 32'(pri), 32'd0);
    step(1, 0, 1, 5'd6, 32'h66666666, 1, 5'd8, 32'h88888888);
    chk("sel_rst", 32'(wr_sel), 32'd0);
    step(1, 0, 0, 5'd0, 32'h0, 1, 5'd8, 32'h88888888);
    step(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
